// File: rtl/aes_sbox_pipe.sv
// Elastic, pipelined AES S-box engine: substitutes NUM_SBOX bytes per transfer,
// forward or inverse per transfer, with valid/ready handshakes on both sides.
module aes_sbox_pipe #(
    parameter int NUM_SBOX    = 4,
    parameter int PIPE_STAGES = 2,
    parameter int SUPPORT_INV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*NUM_SBOX-1:0]   in_data,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*NUM_SBOX-1:0]   out_data,
    output logic                    out_inv,
    output logic                    busy
);
    localparam int         W       = 8 * NUM_SBOX;
    localparam logic [1:0] NS      = PIPE_STAGES[1:0];
    localparam logic       HAS_INV = SUPPORT_INV[0];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ {x[3:0], x[7:4]} ^ {x[4:0], x[7:5]} ^ {x[5:0], x[7:6]}
                 ^ {x[6:0], x[7]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
    endfunction

    function automatic logic [W-1:0] lin_layer(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int k = 0; k < NUM_SBOX; k++) begin
            r[8*k +: 8] = inv ? affine_inv(d[8*k +: 8]) : d[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] inv_layer(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < NUM_SBOX; k++) begin
            r[8*k +: 8] = gf_inv(d[8*k +: 8]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] post_layer(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int k = 0; k < NUM_SBOX; k++) begin
            r[8*k +: 8] = inv ? d[8*k +: 8] : affine_fwd(d[8*k +: 8]);
        end
        return r;
    endfunction

    logic [3:1]   v_r;
    logic [3:1]   i_r;
    logic [W-1:0] d_r [1:3];
    logic [W-1:0] nxt_d_s [1:3];
    logic         inv_in_s;
    logic         l1_s, l2_s, l3_s;
    logic         dr1_s, dr2_s, dr3_s;
    logic         in_ready_s;
    logic [W-1:0] res_s;
    logic         last_v_s;
    logic         last_i_s;

    // Datapath feeding each stage; stages beyond PIPE_STAGES never load.
    always_comb begin
        inv_in_s   = HAS_INV ? in_inv : 1'b0;
        nxt_d_s[1] = lin_layer(in_data, inv_in_s);
        nxt_d_s[2] = inv_layer(d_r[1]);
        nxt_d_s[3] = post_layer(d_r[2], i_r[2]);
    end

    // Ready chain resolved back from out_ready: a stage loads when empty or draining.
    always_comb begin
        if (NS == 2'd3) begin
            dr3_s = v_r[3] & out_ready;
            l3_s  = v_r[2] & (~v_r[3] | dr3_s);
        end else begin
            dr3_s = 1'b0;
            l3_s  = 1'b0;
        end
        if (NS == 2'd2) begin
            dr2_s = v_r[2] & out_ready;
        end else if (NS == 2'd3) begin
            dr2_s = l3_s;
        end else begin
            dr2_s = 1'b0;
        end
        if (NS != 2'd1) begin
            l2_s = v_r[1] & (~v_r[2] | dr2_s);
        end else begin
            l2_s = 1'b0;
        end
        if (NS == 2'd1) begin
            dr1_s = v_r[1] & out_ready;
        end else begin
            dr1_s = l2_s;
        end
        in_ready_s = ~v_r[1] | dr1_s;
        l1_s       = in_valid & in_ready_s;
    end

    // Stage registers: valid/mode/data advance together; reset discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r    <= 3'b000;
            i_r    <= 3'b000;
            d_r[1] <= '0;
            d_r[2] <= '0;
            d_r[3] <= '0;
        end else begin
            v_r <= {l3_s, l2_s, l1_s} | (v_r & ~{dr3_s, dr2_s, dr1_s});
            if (l1_s) begin
                d_r[1] <= nxt_d_s[1];
                i_r[1] <= inv_in_s;
            end
            if (l2_s) begin
                d_r[2] <= nxt_d_s[2];
                i_r[2] <= i_r[1];
            end
            if (l3_s) begin
                d_r[3] <= nxt_d_s[3];
                i_r[3] <= i_r[2];
            end
        end
    end

    // Remaining layers after the last stage; output forced to zero when empty.
    always_comb begin
        case (NS)
            2'd1: begin
                res_s    = post_layer(inv_layer(d_r[1]), i_r[1]);
                last_v_s = v_r[1];
                last_i_s = i_r[1];
            end
            2'd2: begin
                res_s    = nxt_d_s[3];
                last_v_s = v_r[2];
                last_i_s = i_r[2];
            end
            2'd3: begin
                res_s    = d_r[3];
                last_v_s = v_r[3];
                last_i_s = i_r[3];
            end
            default: begin
                res_s    = '0;
                last_v_s = 1'b0;
                last_i_s = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_s;
    assign out_valid = last_v_s;
    assign out_data  = last_v_s ? res_s : '0;
    assign out_inv   = last_v_s & last_i_s;
    assign busy      = |v_r;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Self-checking bench for aes_sbox_pipe: FIPS-197 table model with a scoreboard
// queue for the default configuration, plus two reduced-parameter instances.
module tb_aes_sbox_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, busy;
    logic [31:0]  in_data, out_data;
    logic         p1_in_valid, p1_in_ready, p1_in_inv, p1_out_valid, p1_out_ready, p1_out_inv, p1_busy;
    logic [7:0]   p1_in_data, p1_out_data;
    logic         p3_in_valid, p3_in_ready, p3_in_inv, p3_out_valid, p3_out_ready, p3_out_inv, p3_busy;
    logic [127:0] p3_in_data, p3_out_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  sbox_t [256];
    logic [7:0]  isbox_t [256];
    logic [127:0] rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    aes_sbox_pipe #(.NUM_SBOX(4), .PIPE_STAGES(2), .SUPPORT_INV(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inv(out_inv), .busy(busy));

    aes_sbox_pipe #(.NUM_SBOX(1), .PIPE_STAGES(1), .SUPPORT_INV(0)) dut_p1 (
        .clk(clk), .rst(rst), .in_valid(p1_in_valid), .in_ready(p1_in_ready), .in_data(p1_in_data),
        .in_inv(p1_in_inv), .out_valid(p1_out_valid), .out_ready(p1_out_ready), .out_data(p1_out_data),
        .out_inv(p1_out_inv), .busy(p1_busy));

    aes_sbox_pipe #(.NUM_SBOX(16), .PIPE_STAGES(3), .SUPPORT_INV(0)) dut_p3 (
        .clk(clk), .rst(rst), .in_valid(p3_in_valid), .in_ready(p3_in_ready), .in_data(p3_in_data),
        .in_inv(p3_in_inv), .out_valid(p3_out_valid), .out_ready(p3_out_ready), .out_data(p3_out_data),
        .out_inv(p3_out_inv), .busy(p3_busy));

    function automatic logic [31:0] ref32(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = inv ? isbox_t[d[8*k +: 8]] : sbox_t[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] ref128(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_t[d[8*k +: 8]];
        return r;
    endfunction

    // One cycle on the main DUT: scoreboard push on accept, pop and compare on output.
    task automatic tick(input logic [32:0] exp, output logic acc, output logic ofire);
        logic [32:0] e;
        #1;
        acc   = in_valid && in_ready;
        ofire = out_valid && out_ready;
        if (ofire) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got %b/%h, required no output", out_inv, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_inv, out_data} !== e) begin
                    n_bad++;
                    $display("FAIL sb_data: got %b/%h, required %b/%h", out_inv, out_data, e[32], e[31:0]);
                end
            end
        end
        if (acc) exp_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic flush();
        logic a, o;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) tick(33'h0, a, o);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic send_one(input logic [31:0] d, input logic inv, output logic [31:0] od,
                            output logic oi, output int lat);
        logic acc;
        logic got;
        in_valid = 1'b1; in_data = d; in_inv = inv; out_ready = 1'b1;
        #1 acc = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0; od = 32'h0; oi = 1'b0; got = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            #1;
            if (out_valid) begin got = 1'b1; lat = c; od = out_data; oi = out_inv; end
            @(negedge clk);
        end
        if (!acc) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; p1_in_valid = 1'b0; p3_in_valid = 1'b0;
        in_data = 32'h0; p1_in_data = 8'h0; p3_in_data = 128'h0;
        in_inv = 1'b0; p1_in_inv = 1'b0; p3_in_inv = 1'b0;
        out_ready = 1'b1; p1_out_ready = 1'b1; p3_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp += 7;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
        if (out_inv !== 1'b0) begin n_bad++; $display("FAIL rst_out_inv: got %b, required 0", out_inv); end
        if (p1_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_p1_valid: got %b, required 0", p1_out_valid); end
        if (p3_busy !== 1'b0) begin n_bad++; $display("FAIL rst_p3_busy: got %b, required 0", p3_busy); end
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [31:0] od;
        logic oi;
        int lat;
        send_one(32'h53FF0100, 1'b0, od, oi, lat);
        n_cmp += 3;
        if (lat != 2) begin n_bad++; $display("FAIL fwd_latency: got %0d, required 2", lat); end
        if (od !== 32'hED167C63) begin n_bad++; $display("FAIL fwd_vector: got %h, required ed167c63", od); end
        if (oi !== 1'b0) begin n_bad++; $display("FAIL fwd_out_inv: got %b, required 0", oi); end
        send_one(32'hED167C63, 1'b1, od, oi, lat);
        n_cmp += 3;
        if (lat != 2) begin n_bad++; $display("FAIL inv_latency: got %0d, required 2", lat); end
        if (od !== 32'h53FF0100) begin n_bad++; $display("FAIL inv_vector: got %h, required 53ff0100", od); end
        if (oi !== 1'b1) begin n_bad++; $display("FAIL inv_out_inv: got %b, required 1", oi); end
    endtask

    // All 256 bytes forward, inverse, and forward-then-inverse round trip.
    task automatic test_sweep();
        logic a, o;
        logic [31:0] d, e;
        int x;
        out_ready = 1'b1;
        for (int m = 0; m < 3; m++) begin
            for (int w = 0; w < 64; w++) begin
                for (int k = 0; k < 4; k++) begin
                    x = 4 * w + k;
                    case (m)
                        0: begin d[8*k +: 8] = x[7:0]; e[8*k +: 8] = sbox_t[x[7:0]]; end
                        1: begin d[8*k +: 8] = x[7:0]; e[8*k +: 8] = isbox_t[x[7:0]]; end
                        default: begin d[8*k +: 8] = sbox_t[x[7:0]]; e[8*k +: 8] = x[7:0]; end
                    endcase
                end
                in_valid = 1'b1; in_data = d; in_inv = (m != 0);
                a = 1'b0;
                for (int t = 0; t < 20 && !a; t++) tick({(m != 0), e}, a, o);
            end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        logic a, o;
        logic [31:0] d;
        int first, last, cnt;
        first = -1; last = -1; cnt = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            d = $urandom;
            in_valid = (t < 8); in_data = d; in_inv = t[0];
            tick({t[0], ref32(d, t[0])}, a, o);
            if (t < 8) begin
                n_cmp++;
                if (a !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b at %0d, required 1", a, t); end
            end
            if (o) begin
                if (first < 0) first = t;
                last = t;
                cnt++;
            end
        end
        n_cmp += 2;
        if (cnt != 8) begin n_bad++; $display("FAIL b2b_count: got %0d, required 8", cnt); end
        if (last - first != 7) begin n_bad++; $display("FAIL b2b_gapless: got span %0d, required 7", last - first); end
        flush();
    endtask

    task automatic test_backpressure();
        logic a, o;
        logic [31:0] dat [4];
        logic [31:0] hold;
        int idx;
        for (int i = 0; i < 4; i++) dat[i] = $urandom;
        idx = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            in_valid = 1'b1; in_data = dat[idx]; in_inv = idx[0];
            tick({idx[0], ref32(dat[idx], idx[0])}, a, o);
            if (a) idx++;
        end
        #1;
        n_cmp += 3;
        if (idx != 2) begin n_bad++; $display("FAIL bp_accepted: got %0d, required 2", idx); end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
        hold = out_data;
        for (int t = 0; t < 3; t++) begin
            tick(33'h0, a, o);
            #1;
            n_cmp++;
            if (out_data !== hold || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_stable: got %b/%h, required 1/%h", out_valid, out_data, hold);
            end
        end
        out_ready = 1'b1;
        for (int t = 0; t < 20 && idx < 4; t++) begin
            in_valid = 1'b1; in_data = dat[idx]; in_inv = idx[0];
            tick({idx[0], ref32(dat[idx], idx[0])}, a, o);
            if (a) idx++;
        end
        n_cmp++;
        if (idx != 4) begin n_bad++; $display("FAIL bp_all_accepted: got %0d, required 4", idx); end
        flush();
    endtask

    task automatic test_reset_mid();
        logic a, o;
        int acc_cnt, seen;
        acc_cnt = 0; seen = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 6 && acc_cnt < 2; t++) begin
            in_valid = 1'b1; in_data = $urandom; in_inv = 1'b0;
            tick({1'b0, ref32(in_data, 1'b0)}, a, o);
            if (a) acc_cnt++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b, required 0", out_valid); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b, required 1", in_ready); end
        exp_q.delete();
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick(33'h0, a, o);
            if (o) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL rmid_ghost: got %0d outputs, required 0", seen); end
    endtask

    // Reduced/enlarged configurations, forward-only: in_inv must be ignored.
    task automatic test_params();
        logic [7:0] xs [4];
        logic [127:0] w;
        logic acc, got;
        int lat;
        xs[0] = 8'h53; xs[1] = 8'h00; xs[2] = 8'hff; xs[3] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            p1_in_valid = 1'b1; p1_in_data = xs[i]; p1_in_inv = 1'b1; p1_out_ready = 1'b1;
            #1 acc = p1_in_ready;
            @(negedge clk);
            p1_in_valid = 1'b0;
            got = 1'b0; lat = 0;
            for (int c = 1; c <= 8 && !got; c++) begin
                #1;
                if (p1_out_valid) begin
                    got = 1'b1; lat = acc ? c : -1;
                    n_cmp += 2;
                    if (p1_out_data !== sbox_t[xs[i]]) begin n_bad++; $display("FAIL p1_data: got %h, required %h", p1_out_data, sbox_t[xs[i]]); end
                    if (p1_out_inv !== 1'b0) begin n_bad++; $display("FAIL p1_out_inv: got %b, required 0", p1_out_inv); end
                end
                @(negedge clk);
            end
            n_cmp++;
            if (lat != 1) begin n_bad++; $display("FAIL p1_latency: got %0d, required 1", lat); end
        end
        for (int i = 0; i < 3; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            p3_in_valid = 1'b1; p3_in_data = w; p3_in_inv = 1'b1; p3_out_ready = 1'b1;
            #1 acc = p3_in_ready;
            @(negedge clk);
            p3_in_valid = 1'b0;
            got = 1'b0; lat = 0;
            for (int c = 1; c <= 8 && !got; c++) begin
                #1;
                if (p3_out_valid) begin
                    got = 1'b1; lat = acc ? c : -1;
                    n_cmp += 2;
                    if (p3_out_data !== ref128(w)) begin n_bad++; $display("FAIL p3_data: got %h, required %h", p3_out_data, ref128(w)); end
                    if (p3_out_inv !== 1'b0) begin n_bad++; $display("FAIL p3_out_inv: got %b, required 0", p3_out_inv); end
                end
                @(negedge clk);
            end
            n_cmp++;
            if (lat != 3) begin n_bad++; $display("FAIL p3_latency: got %0d, required 3", lat); end
        end
    endtask

    initial begin
        logic [7:0] v;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                v = 8'(r * 16 + c);
                sbox_t[v] = rows[r][127 - 8 * c -: 8];
            end
        end
        for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
        test_reset();
        test_vectors();
        test_sweep();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
